// File: rtl/psram_qpi_responder.sv
// psram_qpi_responder
//   Device-side QPI PSRAM model. It oversamples the quad-SPI pins in the clk
//   domain and answers enter-QPI (35h, serial), quad read (EBh), quad write
//   (38h) and exit-QPI (F5h) from an internal 2^ADDR_W byte array.
//
// Parameters
//   ADDR_W : byte-address width of the array; upper bus-address bits ignored
//   DUMMY  : wait SCK cycles between address and read data
//
// Ports
//   clk      : system clock, at least 4x the SCK frequency
//   rst_n    : asynchronous active-low reset (array contents are kept)
//   sck      : PSRAM serial clock from the controller
//   ce_n     : chip enable, active low
//   sio_i    : controller data out (bit 0 is SI in SPI mode)
//   sio_o    : read data to the controller
//   sio_oe   : high while sio_o is driven
//   qpi_mode : device is in QPI mode
//
// Build option
//   PSRAM_RESP_QPI_BOOT_EN : when defined, qpi_mode resets to 1.

module psram_qpi_responder #(
    parameter int ADDR_W = 16,
    parameter int DUMMY  = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sck,
    input  logic       ce_n,
    input  logic [3:0] sio_i,
    output logic [3:0] sio_o,
    output logic       sio_oe,
    output logic       qpi_mode
);

`ifdef PSRAM_RESP_QPI_BOOT_EN
    localparam logic QPI_RST = 1'b1;
`else
    localparam logic QPI_RST = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_RDATA,
        S_WDATA,
        S_IGNORE
    } state_t;

    // Input conditioning
    logic [2:0] sck_s_q;
    logic [1:0] ce_s_q;
    logic [3:0] sio_s1_q, sio_s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_s_q  <= '0;
            ce_s_q   <= '1;
            sio_s1_q <= '0;
            sio_s2_q <= '0;
        end else begin
            sck_s_q  <= {sck_s_q[1:0], sck};
            ce_s_q   <= {ce_s_q[0], ce_n};
            sio_s1_q <= sio_i;
            sio_s2_q <= sio_s1_q;
        end
    end

    logic sck_rise, sck_fall, ce_hi;
    assign sck_rise = sck_s_q[1] & ~sck_s_q[2];
    assign sck_fall = ~sck_s_q[1] & sck_s_q[2];
    assign ce_hi    = ce_s_q[1];

    // Protocol state
    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [6:0]          sh_q, sh_d;      // previously sampled command bits
    logic                rd_q, rd_d;      // 1: EBh, 0: 38h
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                half_q, half_d;  // high nibble already handled
    logic [3:0]          wbuf_q, wbuf_d;
    logic [3:0]          sio_o_q, sio_o_d;
    logic                oe_q, oe_d;
    logic                qpi_q, qpi_d;
    logic                mem_we;
    logic [7:0]          mem_wdata;
    logic [7:0]          rd_byte;
    logic [7:0]          spi_byte, qpi_byte;

    logic [7:0] mem_q [2**ADDR_W];

    assign rd_byte  = mem_q[addr_q];
    assign spi_byte = {sh_q, sio_s2_q[0]};
    assign qpi_byte = {sh_q[3:0], sio_s2_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            half_q  <= 1'b0;
            wbuf_q  <= '0;
            sio_o_q <= '0;
            oe_q    <= 1'b0;
            qpi_q   <= QPI_RST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            half_q  <= half_d;
            wbuf_q  <= wbuf_d;
            sio_o_q <= sio_o_d;
            oe_q    <= oe_d;
            qpi_q   <= qpi_d;
        end
    end

    // Array is deliberately outside the reset domain so data survives rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr_q] <= mem_wdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        rd_d      = rd_q;
        addr_d    = addr_q;
        half_d    = half_q;
        wbuf_d    = wbuf_q;
        sio_o_d   = sio_o_q;
        oe_d      = oe_q;
        qpi_d     = qpi_q;
        mem_we    = 1'b0;
        mem_wdata = {wbuf_q, sio_s2_q};

        if (ce_hi) begin
            // Deselect wins over any strobe in the same cycle.
            state_d = S_IDLE;
            cnt_d   = '0;
            half_d  = 1'b0;
            oe_d    = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_CMD;
                    cnt_d   = '0;
                    half_d  = 1'b0;
                end
                S_CMD: begin
                    if (sck_rise) begin
                        cnt_d = cnt_q + 8'd1;
                        if (!qpi_q) begin
                            sh_d = 7'(spi_byte);
                            if (cnt_q == 8'd7) begin
                                if (spi_byte == 8'h35) qpi_d = 1'b1;
                                state_d = S_IGNORE;
                            end
                        end else begin
                            sh_d = 7'(qpi_byte);
                            if (cnt_q == 8'd1) begin
                                cnt_d   = '0;
                                state_d = S_IGNORE;
                                if (qpi_byte == 8'hEB) begin
                                    rd_d    = 1'b1;
                                    state_d = S_ADDR;
                                end else if (qpi_byte == 8'h38) begin
                                    rd_d    = 1'b0;
                                    state_d = S_ADDR;
                                end else if (qpi_byte == 8'hF5) begin
                                    qpi_d = 1'b0;
                                end
                            end
                        end
                    end
                end
                S_ADDR: begin
                    if (sck_rise) begin
                        // Shifting through an ADDR_W-wide register keeps only
                        // the low bits of the 24-bit bus address.
                        addr_d = ADDR_W'({addr_q, sio_s2_q});
                        cnt_d  = cnt_q + 8'd1;
                        if (cnt_q == 8'd5) begin
                            cnt_d  = '0;
                            half_d = 1'b0;
                            if (!rd_q)           state_d = S_WDATA;
                            else if (DUMMY == 0) state_d = S_RDATA;
                            else                 state_d = S_DUMMY;
                        end
                    end
                end
                S_DUMMY: begin
                    if (sck_rise) begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q == 8'(DUMMY - 1)) begin
                            cnt_d   = '0;
                            state_d = S_RDATA;
                        end
                    end
                end
                S_RDATA: begin
                    if (sck_fall) begin
                        oe_d = 1'b1;
                        if (!half_q) begin
                            sio_o_d = rd_byte[7:4];
                            half_d  = 1'b1;
                        end else begin
                            sio_o_d = rd_byte[3:0];
                            half_d  = 1'b0;
                            addr_d  = addr_q + 1'b1;
                        end
                    end
                end
                S_WDATA: begin
                    if (sck_rise) begin
                        if (!half_q) begin
                            wbuf_d = sio_s2_q;
                            half_d = 1'b1;
                        end else begin
                            mem_we = 1'b1;
                            half_d = 1'b0;
                            addr_d = addr_q + 1'b1;
                        end
                    end
                end
                S_IGNORE: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign sio_o    = sio_o_q;
    assign sio_oe   = oe_q;
    assign qpi_mode = qpi_q;

endmodule

// File: tb/tb_psram_qpi_responder.sv
// tb_psram_qpi_responder
//   Directed bench acting as the PSRAM controller. A byte-array model of the
//   device plus a mode bit supply the expected read nibbles, drive windows and
//   mode; a single compare process checks the DUT against them every clk.
//   Literal checks pin the model at key points.

module tb_psram_qpi_responder;

`ifdef PSRAM_RESP_QPI_BOOT_EN
    localparam logic RST_QPI = 1'b1;
`else
    localparam logic RST_QPI = 1'b0;
`endif
    localparam int DUMMY = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck = 1'b0;
    logic       ce_n = 1'b1;
    logic [3:0] sio_i = '0;
    logic [3:0] sio_o;
    logic       sio_oe;
    logic       qpi_mode;

    psram_qpi_responder #(.ADDR_W(16), .DUMMY(DUMMY)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sck      (sck),
        .ce_n     (ce_n),
        .sio_i    (sio_i),
        .sio_o    (sio_o),
        .sio_oe   (sio_oe),
        .qpi_mode (qpi_mode)
    );

    always #5 clk = ~clk;

    // Model state
    logic [7:0]  model_mem [65536];
    logic        model_qpi = RST_QPI;
    logic [15:0] rd_base = '0;
    logic        rd_window = 1'b0;
    logic        settled = 1'b0;
    logic        smp_req = 1'b0;
    int          smp_k = 0;
    logic [7:0]  wr_q [$];
    logic [7:0]  rd_q [$];

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Compare process
    initial begin
        logic [15:0] a;
        logic [7:0]  b;
        logic [3:0]  e;
        forever begin
            @(negedge clk);
            #1;
            if (smp_req) begin
                a = rd_base + 16'(smp_k / 2);
                b = model_mem[a];
                e = (smp_k % 2 == 0) ? b[7:4] : b[3:0];
                chk(sio_oe === 1'b1 && sio_o === e, "rd_nibble", {sio_oe, sio_o}, {1'b1, e});
            end else if (!rd_window) begin
                chk(sio_oe === 1'b0, "oe_idle", sio_oe, 0);
            end
            if (settled) chk(qpi_mode === model_qpi, "qpi_mode", qpi_mode, model_qpi);
        end
    end

    // One SCK period (8 clk): data set while low, rise, fall.
    task automatic sck_cycle(input logic [3:0] d, input bit smp, input int k, output logic [3:0] got);
        sio_i = d;
        repeat (2) @(negedge clk);
        got = sio_o;
        smp_k = k;
        smp_req = smp;
        sck = 1'b1;
        @(negedge clk);
        smp_req = 1'b0;
        repeat (3) @(negedge clk);
        sck = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic start_txn();
        settled = 1'b0;
        ce_n = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic finish_txn(input logic new_mode);
        sck = 1'b0;
        ce_n = 1'b1;
        repeat (4) @(negedge clk);
        chk(sio_oe === 1'b0, "oe_after_ce", sio_oe, 0);
        repeat (2) @(negedge clk);
        model_qpi = new_mode;
        rd_window = 1'b0;
        settled = 1'b1;
    endtask

    task automatic send_byte_qpi(input logic [7:0] v);
        logic [3:0] g;
        sck_cycle(v[7:4], 1'b0, 0, g);
        sck_cycle(v[3:0], 1'b0, 0, g);
    endtask

    task automatic send_addr(input logic [23:0] a);
        logic [3:0] g;
        for (int i = 5; i >= 0; i--) sck_cycle(a[i*4 +: 4], 1'b0, 0, g);
    endtask

    task automatic enter_qpi();
        logic [7:0] c;
        logic [3:0] g;
        c = 8'h35;
        start_txn();
        for (int i = 7; i >= 1; i--) sck_cycle({3'b000, c[i]}, 1'b0, 0, g);
        sio_i = {3'b000, c[0]};
        repeat (2) @(negedge clk);
        sck = 1'b1;
        repeat (4) @(negedge clk);
        chk(qpi_mode === 1'b1, "qpi_after_35", qpi_mode, 1);
        sck = 1'b0;
        repeat (2) @(negedge clk);
        finish_txn(1'b1);
    endtask

    // Writes wr_q from address a, then optionally one dangling nibble.
    task automatic qpi_write(input logic [23:0] a, input bit extra, input logic [3:0] xn);
        logic [3:0] g;
        start_txn();
        send_byte_qpi(8'h38);
        send_addr(a);
        for (int i = 0; i < wr_q.size(); i++) begin
            send_byte_qpi(wr_q[i]);
            model_mem[a[15:0] + 16'(i)] = wr_q[i];
        end
        if (extra) sck_cycle(xn, 1'b0, 0, g);
        finish_txn(model_qpi);
    endtask

    // Reads nnib nibbles; drive=0 means the device is expected to stay silent.
    task automatic qpi_read(input logic [23:0] a, input int nnib, input bit drive);
        logic [3:0] g, hi;
        hi = '0;
        start_txn();
        send_byte_qpi(8'hEB);
        send_addr(a);
        rd_base = a[15:0];
        rd_window = drive;
        for (int i = 0; i < DUMMY; i++) sck_cycle(4'h0, 1'b0, 0, g);
        rd_q.delete();
        for (int k = 0; k < nnib; k++) begin
            sck_cycle(4'h0, drive, k, g);
            if (k % 2 == 1) rd_q.push_back({hi, g});
            else hi = g;
        end
        finish_txn(model_qpi);
    endtask

    initial begin
        logic [7:0] exp4 [4];
        logic [3:0] g;
        exp4 = '{8'hA5, 8'h3C, 8'h7E, 8'h81};

        // Reset state
        repeat (5) @(negedge clk);
        chk(sio_oe === 1'b0, "rst_oe", sio_oe, 0);
        chk(sio_o === 4'h0, "rst_sio_o", sio_o, 0);
        chk(qpi_mode === RST_QPI, "rst_qpi", qpi_mode, RST_QPI);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        settled = 1'b1;

        // Enter QPI, write and read back
        enter_qpi();
        wr_q = '{8'hA5, 8'h3C, 8'h7E, 8'h81};
        qpi_write(24'h000100, 1'b0, 4'h0);
        qpi_read(24'h000100, 8, 1'b1);
        for (int i = 0; i < 4; i++) chk(rd_q[i] === exp4[i], "lit_rd100", rd_q[i], exp4[i]);

        // Wrap from top of array to 0
        wr_q = '{8'h11, 8'h22};
        qpi_write(24'h00FFFF, 1'b0, 4'h0);
        qpi_read(24'h00FFFF, 4, 1'b1);
        chk(rd_q[0] === 8'h11, "lit_wrap0", rd_q[0], 8'h11);
        chk(rd_q[1] === 8'h22, "lit_wrap1", rd_q[1], 8'h22);
        qpi_read(24'h000000, 2, 1'b1);
        chk(rd_q[0] === 8'h22, "lit_mem0", rd_q[0], 8'h22);

        // Partial byte discarded
        wr_q = '{8'h55, 8'h66};
        qpi_write(24'h000200, 1'b0, 4'h0);
        wr_q = '{8'hDE};
        qpi_write(24'h000200, 1'b1, 4'h9);
        qpi_read(24'h000200, 4, 1'b1);
        chk(rd_q[0] === 8'hDE, "lit_part0", rd_q[0], 8'hDE);
        chk(rd_q[1] === 8'h66, "lit_part1", rd_q[1], 8'h66);

        // ce_n raised mid-read (oe check is inside finish_txn)
        qpi_read(24'h000100, 3, 1'b1);

        // Unknown command, then exit QPI, then an EBh that must be ignored
        start_txn();
        send_byte_qpi(8'h9F);
        for (int i = 0; i < 8; i++) sck_cycle(4'($urandom_range(0, 15)), 1'b0, 0, g);
        finish_txn(model_qpi);
        chk(qpi_mode === 1'b1, "qpi_after_9f", qpi_mode, 1);
        start_txn();
        send_byte_qpi(8'hF5);
        finish_txn(1'b0);
        chk(qpi_mode === 1'b0, "qpi_after_f5", qpi_mode, 0);
        qpi_read(24'h000100, 4, 1'b0);
        chk(qpi_mode === 1'b0, "qpi_after_ign_eb", qpi_mode, 0);

        // Reset during RDATA
        enter_qpi();
        start_txn();
        send_byte_qpi(8'hEB);
        send_addr(24'h000100);
        rd_base = 16'h0100;
        rd_window = 1'b1;
        for (int i = 0; i < DUMMY; i++) sck_cycle(4'h0, 1'b0, 0, g);
        for (int k = 0; k < 2; k++) sck_cycle(4'h0, 1'b1, k, g);
        chk(sio_oe === 1'b1, "oe_before_rst", sio_oe, 1);
        rst_n = 1'b0;
        #1;
        chk(sio_oe === 1'b0, "oe_async_rst", sio_oe, 0);
        chk(qpi_mode === RST_QPI, "qpi_async_rst", qpi_mode, RST_QPI);
        repeat (3) @(negedge clk);
        ce_n = 1'b1;
        sck = 1'b0;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        model_qpi = RST_QPI;
        rd_window = 1'b0;
        settled = 1'b1;
        enter_qpi();
        qpi_read(24'h000100, 8, 1'b1);
        for (int i = 0; i < 4; i++) chk(rd_q[i] === exp4[i], "lit_after_rst", rd_q[i], exp4[i]);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
